// File: rtl/ip_tx.sv
// IPv4 transmit encapsulator: prefixes a byte stream with a 20-byte header carrying
// dummy length/checksum bytes, then reports the true values on a side channel at packet end.
module ip_tx #(
    parameter int AXI_DATA_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    output logic                      s_ip_hdr_trdy,
    input  logic                      s_ip_hdr_tvalid,
    input  logic [7:0]                s_ip_tos,
    input  logic [15:0]               s_ip_id,
    input  logic [7:0]                s_ip_ttl,
    input  logic [7:0]                s_ip_protocol,
    input  logic [31:0]               s_ip_src_addr,
    input  logic [31:0]               s_ip_dst_addr,
    input  logic [AXI_DATA_WIDTH-1:0] s_tx_axis_tdata,
    input  logic                      s_tx_axis_tvalid,
    input  logic                      s_tx_axis_tlast,
    output logic                      s_tx_axis_trdy,
    output logic [AXI_DATA_WIDTH-1:0] m_tx_axis_tdata,
    output logic                      m_tx_axis_tvalid,
    output logic                      m_tx_axis_tlast,
    input  logic                      m_tx_axis_trdy,
    output logic                      m_ip_info_tvalid,
    output logic [15:0]               m_ip_total_len,
    output logic [15:0]               m_ip_hdr_checksum
);

    typedef enum logic [1:0] {IDLE, IP_HDR, IP_PAYLOAD} state_t;

    state_t      state;
    logic [4:0]  hdr_idx;
    logic [4:0]  hdr_next;
    logic [15:0] pay_count;
    logic [7:0]  tos;
    logic [15:0] id;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [19:0] fixed_sum;
    logic [7:0]  next_hdr_byte;
    logic [15:0] final_len;
    logic [19:0] full_sum;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic        out_hs;
    logic        in_hs;

    assign out_hs         = m_tx_axis_tvalid & m_tx_axis_trdy;
    assign in_hs          = s_tx_axis_tvalid & s_tx_axis_trdy;
    assign s_ip_hdr_trdy  = (state == IDLE) && !m_tx_axis_tvalid;
    assign s_tx_axis_trdy = (state == IP_PAYLOAD) && (m_tx_axis_trdy || !m_tx_axis_tvalid);
    assign hdr_next       = hdr_idx + 5'd1;

    always_comb begin
        next_hdr_byte = 8'h00;
        case (hdr_next)
            5'd0:  next_hdr_byte = 8'h45;
            5'd1:  next_hdr_byte = tos;
            5'd2:  next_hdr_byte = 8'hBE;
            5'd3:  next_hdr_byte = 8'hEF;
            5'd4:  next_hdr_byte = id[15:8];
            5'd5:  next_hdr_byte = id[7:0];
            5'd6:  next_hdr_byte = 8'h40;
            5'd7:  next_hdr_byte = 8'h00;
            5'd8:  next_hdr_byte = ttl;
            5'd9:  next_hdr_byte = protocol;
            5'd10: next_hdr_byte = 8'hDE;
            5'd11: next_hdr_byte = 8'hAD;
            5'd12: next_hdr_byte = src_addr[31:24];
            5'd13: next_hdr_byte = src_addr[23:16];
            5'd14: next_hdr_byte = src_addr[15:8];
            5'd15: next_hdr_byte = src_addr[7:0];
            5'd16: next_hdr_byte = dst_addr[31:24];
            5'd17: next_hdr_byte = dst_addr[23:16];
            5'd18: next_hdr_byte = dst_addr[15:8];
            5'd19: next_hdr_byte = dst_addr[7:0];
            default: next_hdr_byte = 8'h00;
        endcase
    end

    // The count still excludes the tlast byte when this is consumed, hence 21 rather than 20.
    always_comb begin
        final_len = 16'd21 + pay_count;
        full_sum  = fixed_sum + 20'(final_len);
        fold1     = 17'(full_sum[15:0]) + 17'(full_sum[19:16]);
        fold2     = fold1[15:0] + 16'(fold1[16]);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state             <= IDLE;
            hdr_idx           <= 5'd0;
            pay_count         <= 16'd0;
            tos               <= 8'h00;
            id                <= 16'h0000;
            ttl               <= 8'h00;
            protocol          <= 8'h00;
            src_addr          <= 32'h0;
            dst_addr          <= 32'h0;
            fixed_sum         <= 20'h0;
            m_tx_axis_tdata   <= '0;
            m_tx_axis_tvalid  <= 1'b0;
            m_tx_axis_tlast   <= 1'b0;
            m_ip_info_tvalid  <= 1'b0;
            m_ip_total_len    <= 16'h0;
            m_ip_hdr_checksum <= 16'h0;
        end else begin
            m_ip_info_tvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_ip_hdr_tvalid && s_ip_hdr_trdy) begin
                        tos              <= s_ip_tos;
                        id               <= s_ip_id;
                        ttl              <= s_ip_ttl;
                        protocol         <= s_ip_protocol;
                        src_addr         <= s_ip_src_addr;
                        dst_addr         <= s_ip_dst_addr;
                        pay_count        <= 16'd0;
                        hdr_idx          <= 5'd0;
                        m_tx_axis_tdata  <= 8'h45;
                        m_tx_axis_tvalid <= 1'b1;
                        m_tx_axis_tlast  <= 1'b0;
                        state            <= IP_HDR;
                    end else if (out_hs) begin
                        m_tx_axis_tvalid <= 1'b0;
                        m_tx_axis_tlast  <= 1'b0;
                    end
                end
                IP_HDR: begin
                    // Fields are frozen here, so the length-independent part of the sum is ready long before packet end.
                    fixed_sum <= 20'({8'h45, tos}) + 20'(id) + 20'h04000 + 20'({ttl, protocol})
                               + 20'(src_addr[31:16]) + 20'(src_addr[15:0])
                               + 20'(dst_addr[31:16]) + 20'(dst_addr[15:0]);
                    if (out_hs) begin
                        if (hdr_idx == 5'd19) begin
                            m_tx_axis_tvalid <= 1'b0;
                            state            <= IP_PAYLOAD;
                        end else begin
                            hdr_idx         <= hdr_next;
                            m_tx_axis_tdata <= next_hdr_byte;
                        end
                    end
                end
                IP_PAYLOAD: begin
                    if (in_hs) begin
                        m_tx_axis_tdata  <= s_tx_axis_tdata;
                        m_tx_axis_tlast  <= s_tx_axis_tlast;
                        m_tx_axis_tvalid <= 1'b1;
                        pay_count        <= pay_count + 16'd1;
                        if (s_tx_axis_tlast) begin
                            state             <= IDLE;
                            m_ip_info_tvalid  <= 1'b1;
                            m_ip_total_len    <= final_len;
                            m_ip_hdr_checksum <= ~fold2;
                        end
                    end else if (out_hs) begin
                        m_tx_axis_tvalid <= 1'b0;
                        m_tx_axis_tlast  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_tx.sv
// Randomized self-checking bench for ip_tx: a per-packet reference model builds the
// expected byte stream and side-channel values; a negedge monitor scores the DUT.
module tb_ip_tx;

    localparam int MAXP = 16;
    localparam int MAXL = 40;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        s_ip_hdr_trdy;
    logic        s_ip_hdr_tvalid = 1'b0;
    logic [7:0]  s_ip_tos = '0;
    logic [15:0] s_ip_id = '0;
    logic [7:0]  s_ip_ttl = '0;
    logic [7:0]  s_ip_protocol = '0;
    logic [31:0] s_ip_src_addr = '0;
    logic [31:0] s_ip_dst_addr = '0;
    logic [7:0]  s_tx_axis_tdata = '0;
    logic        s_tx_axis_tvalid = 1'b0;
    logic        s_tx_axis_tlast = 1'b0;
    logic        s_tx_axis_trdy;
    logic [7:0]  m_tx_axis_tdata;
    logic        m_tx_axis_tvalid;
    logic        m_tx_axis_tlast;
    logic        m_tx_axis_trdy = 1'b1;
    logic        m_ip_info_tvalid;
    logic [15:0] m_ip_total_len;
    logic [15:0] m_ip_hdr_checksum;

    ip_tx #(.AXI_DATA_WIDTH(8)) dut (
        .i_clk             (i_clk),
        .i_reset_n         (i_reset_n),
        .s_ip_hdr_trdy     (s_ip_hdr_trdy),
        .s_ip_hdr_tvalid   (s_ip_hdr_tvalid),
        .s_ip_tos          (s_ip_tos),
        .s_ip_id           (s_ip_id),
        .s_ip_ttl          (s_ip_ttl),
        .s_ip_protocol     (s_ip_protocol),
        .s_ip_src_addr     (s_ip_src_addr),
        .s_ip_dst_addr     (s_ip_dst_addr),
        .s_tx_axis_tdata   (s_tx_axis_tdata),
        .s_tx_axis_tvalid  (s_tx_axis_tvalid),
        .s_tx_axis_tlast   (s_tx_axis_tlast),
        .s_tx_axis_trdy    (s_tx_axis_trdy),
        .m_tx_axis_tdata   (m_tx_axis_tdata),
        .m_tx_axis_tvalid  (m_tx_axis_tvalid),
        .m_tx_axis_tlast   (m_tx_axis_tlast),
        .m_tx_axis_trdy    (m_tx_axis_trdy),
        .m_ip_info_tvalid  (m_ip_info_tvalid),
        .m_ip_total_len    (m_ip_total_len),
        .m_ip_hdr_checksum (m_ip_hdr_checksum)
    );

    always #5 i_clk = ~i_clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  p_tos[MAXP];
    logic [15:0] p_id[MAXP];
    logic [7:0]  p_ttl[MAXP];
    logic [7:0]  p_proto[MAXP];
    logic [31:0] p_src[MAXP];
    logic [31:0] p_dst[MAXP];
    int          p_len[MAXP];
    logic [7:0]  p_pay[MAXP][MAXL];

    logic [8:0]  exp_q[$];
    logic [31:0] info_q[$];
    bit          hdr_accepted[MAXP];
    int          cur_hdr_pkt = 0;
    bit          bp_mode = 1'b0;

    bit          pkt_active = 1'b0;
    int          hdr_seen = 0;
    bit          rst_seen = 1'b0;
    bit          prev_hdr_hs = 1'b0;
    bit          prev_in_hs = 1'b0;
    bit          prev_in_last = 1'b0;
    logic [7:0]  prev_in_data = '0;
    bit          prev_stall = 1'b0;
    logic [9:0]  prev_out = '0;
    logic [31:0] held_info = '0;
    logic [8:0]  exp_beat;
    logic [31:0] exp_info;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic stopOnTimeout(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkOutput(tag, observed, expected);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    endtask

    // Reference: the packet as it should appear on the wire, and its RFC 791 length/checksum.
    function automatic void model_packet(input int k);
        logic [7:0]  hdr[20];
        logic [15:0] tl;
        int unsigned sum;
        tl  = 16'(20 + p_len[k]);
        hdr = '{8'h45, p_tos[k], 8'hBE, 8'hEF, p_id[k][15:8], p_id[k][7:0], 8'h40, 8'h00,
                p_ttl[k], p_proto[k], 8'hDE, 8'hAD,
                p_src[k][31:24], p_src[k][23:16], p_src[k][15:8], p_src[k][7:0],
                p_dst[k][31:24], p_dst[k][23:16], p_dst[k][15:8], p_dst[k][7:0]};
        for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, hdr[i]});
        for (int i = 0; i < p_len[k]; i++) exp_q.push_back({(i == p_len[k] - 1), p_pay[k][i]});
        hdr[2]  = tl[15:8];
        hdr[3]  = tl[7:0];
        hdr[10] = 8'h00;
        hdr[11] = 8'h00;
        sum = 0;
        for (int i = 0; i < 10; i++) sum += {hdr[2*i], hdr[2*i+1]};
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        info_q.push_back({tl, ~sum[15:0]});
    endfunction

    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            exp_q.delete();
            info_q.delete();
            pkt_active   = 1'b0;
            hdr_seen     = 0;
            held_info    = '0;
            rst_seen     = 1'b1;
            prev_hdr_hs  = 1'b0;
            prev_in_hs   = 1'b0;
            prev_in_last = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            if (rst_seen)
                checkOutput("reset_outputs", {m_tx_axis_tvalid, m_tx_axis_tlast, m_tx_axis_tdata, m_ip_info_tvalid,
                                              m_ip_total_len, m_ip_hdr_checksum, s_tx_axis_trdy}, 64'd0);
            rst_seen = 1'b0;
            checkOutput("hdr_trdy", s_ip_hdr_trdy, !pkt_active);
            if (pkt_active && hdr_seen < 20) checkOutput("pay_trdy_in_hdr", s_tx_axis_trdy, 1'b0);
            if (prev_hdr_hs) checkOutput("hdr_latency", {m_tx_axis_tvalid, m_tx_axis_tdata}, {1'b1, 8'h45});
            if (prev_in_hs)
                checkOutput("pay_latency", {m_tx_axis_tvalid, m_tx_axis_tlast, m_tx_axis_tdata},
                            {1'b1, prev_in_last, prev_in_data});
            if (prev_stall)
                checkOutput("stall_hold", {m_tx_axis_tvalid, m_tx_axis_tlast, m_tx_axis_tdata}, prev_out);
            checkOutput("info_pulse", m_ip_info_tvalid, prev_in_hs && prev_in_last);
            if (m_ip_info_tvalid) begin
                checkOutput("pulse_with_tlast", {m_tx_axis_tvalid, m_tx_axis_tlast}, 2'b11);
                if (info_q.size() == 0) checkOutput("info_unexpected", m_ip_info_tvalid, 1'b0);
                else begin
                    exp_info  = info_q.pop_front();
                    held_info = exp_info;
                    checkOutput("total_len", m_ip_total_len, exp_info[31:16]);
                    checkOutput("checksum", m_ip_hdr_checksum, exp_info[15:0]);
                end
            end else begin
                checkOutput("side_hold", {m_ip_total_len, m_ip_hdr_checksum}, held_info);
            end
            if (m_tx_axis_tvalid && m_tx_axis_trdy) begin
                if (exp_q.size() == 0) checkOutput("beat_unexpected", m_tx_axis_tvalid, 1'b0);
                else begin
                    exp_beat = exp_q.pop_front();
                    checkOutput("beat", {m_tx_axis_tlast, m_tx_axis_tdata}, exp_beat);
                    if (hdr_seen < 20) hdr_seen++;
                    if (exp_beat[8]) pkt_active = 1'b0;
                end
            end
            prev_hdr_hs = s_ip_hdr_tvalid && s_ip_hdr_trdy;
            if (prev_hdr_hs) begin
                pkt_active = 1'b1;
                hdr_seen   = 0;
                hdr_accepted[cur_hdr_pkt] = 1'b1;
                model_packet(cur_hdr_pkt);
            end
            prev_in_hs   = s_tx_axis_tvalid && s_tx_axis_trdy;
            prev_in_last = s_tx_axis_tlast;
            prev_in_data = s_tx_axis_tdata;
            prev_stall   = m_tx_axis_tvalid && !m_tx_axis_trdy;
            prev_out     = {m_tx_axis_tvalid, m_tx_axis_tlast, m_tx_axis_tdata};
        end
    end

    initial begin
        forever begin
            @(posedge i_clk);
            #1 m_tx_axis_trdy = bp_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic drive_headers(input int first, input int count, input bit gaps);
        int budget;
        for (int k = first; k < first + count; k++) begin
            s_ip_tos        = p_tos[k];
            s_ip_id         = p_id[k];
            s_ip_ttl        = p_ttl[k];
            s_ip_protocol   = p_proto[k];
            s_ip_src_addr   = p_src[k];
            s_ip_dst_addr   = p_dst[k];
            cur_hdr_pkt     = k;
            s_ip_hdr_tvalid = 1'b1;
            budget = 5000;
            do begin
                @(negedge i_clk);
                budget--;
            end while (!s_ip_hdr_trdy && budget > 0);
            if (!s_ip_hdr_trdy) stopOnTimeout("hdr_timeout", s_ip_hdr_trdy, 1'b1);
            @(posedge i_clk);
            #1;
            if (gaps && $urandom_range(0, 1) == 1) begin
                s_ip_hdr_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge i_clk);
                #1;
            end
        end
        s_ip_hdr_tvalid = 1'b0;
    endtask

    task automatic drive_payloads(input int first, input int count, input bit gaps, input int abort_pkt);
        int budget;
        bit aborted;
        aborted = 1'b0;
        for (int k = first; k < first + count && !aborted; k++) begin
            budget = 5000;
            while (!hdr_accepted[k] && budget > 0) begin
                @(posedge i_clk);
                #1;
                budget--;
            end
            if (!hdr_accepted[k]) stopOnTimeout("accept_timeout", hdr_accepted[k], 1'b1);
            for (int i = 0; i < p_len[k] && !aborted; i++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    s_tx_axis_tvalid = 1'b0;
                    @(posedge i_clk);
                    #1;
                end
                s_tx_axis_tdata  = p_pay[k][i];
                s_tx_axis_tlast  = (i == p_len[k] - 1);
                s_tx_axis_tvalid = 1'b1;
                budget = 5000;
                do begin
                    @(negedge i_clk);
                    budget--;
                end while (!s_tx_axis_trdy && budget > 0);
                if (!s_tx_axis_trdy) stopOnTimeout("payload_timeout", s_tx_axis_trdy, 1'b1);
                @(posedge i_clk);
                #1;
                if (k == abort_pkt && i == 3) begin
                    s_tx_axis_tvalid = 1'b0;
                    i_reset_n        = 1'b0;
                    @(posedge i_clk);
                    #1 i_reset_n = 1'b1;
                    aborted = 1'b1;
                end
            end
        end
        s_tx_axis_tvalid = 1'b0;
        s_tx_axis_tlast  = 1'b0;
    endtask

    task automatic applyStimulus(input int first, input int count, input bit gaps, input bit bp, input int abort_pkt);
        int budget;
        bp_mode = bp;
        fork
            drive_headers(first, count, gaps);
            drive_payloads(first, count, gaps, abort_pkt);
        join
        budget = 20000;
        while ((exp_q.size() != 0 || pkt_active) && budget > 0) begin
            @(posedge i_clk);
            #1;
            budget--;
        end
        if (budget == 0) stopOnTimeout("drain_timeout", 64'(exp_q.size()) + 64'(pkt_active), 64'd0);
        bp_mode = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    initial begin
        #500000;
        tests_failed++;
        $display("[TB] FAIL watchdog: simulation time 0x%0h exceeded limit 0x%0h", $time, 500000);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < MAXP; k++) begin
            p_tos[k]   = 8'($urandom);
            p_id[k]    = 16'($urandom);
            p_ttl[k]   = 8'($urandom);
            p_proto[k] = 8'($urandom);
            p_src[k]   = $urandom;
            p_dst[k]   = $urandom;
            p_len[k]   = $urandom_range(1, MAXL);
            for (int i = 0; i < MAXL; i++) p_pay[k][i] = 8'($urandom);
        end
        for (int k = 0; k < 3; k++) begin
            p_tos[k]   = 8'h00;
            p_id[k]    = 16'h1234;
            p_ttl[k]   = 8'h40;
            p_proto[k] = 8'h11;
            p_src[k]   = 32'hC0A80001;
            p_dst[k]   = 32'hC0A80002;
            p_len[k]   = (k == 1) ? 1 : 8;
            for (int i = 0; i < 8; i++) p_pay[k][i] = 8'(i + 1);
        end
        p_len[13] = 12;

        repeat (3) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        $display("[TB] nominal packet");
        applyStimulus(0, 1, 1'b0, 1'b0, -1);
        $display("[TB] single-byte payload");
        applyStimulus(1, 1, 1'b0, 1'b0, -1);
        $display("[TB] nominal packet with backpressure");
        applyStimulus(2, 1, 1'b0, 1'b1, -1);
        $display("[TB] random back-to-back packets");
        applyStimulus(3, 10, 1'b1, 1'b1, -1);
        $display("[TB] reset during payload, then recovery");
        applyStimulus(13, 1, 1'b0, 1'b0, 13);
        applyStimulus(14, 2, 1'b1, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
